// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the UART receive operand packer.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } rx_state_e;

   localparam int DEF_SIZE_DATA_I  = 8;
   localparam int DEF_SIZE_DATA_O  = 32;
   localparam int DEF_NUM_OPERANDS = 2;

   // Counter width for a 0..n-1 range, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int bytes_per_operand(input int size_o, input int size_i);
      return size_o / size_i;
   endfunction

   function automatic bit sizes_ok(input int size_o, input int size_i, input int num_ops);
      return (size_i > 0) && (size_o >= size_i) && ((size_o % size_i) == 0) && (num_ops >= 1);
   endfunction

endpackage

// File: rtl/uart_rx_operand_packer_if.sv
// Byte-in / frame-out bundle between the UART receiver, the packer and the FP datapath.
interface uart_rx_operand_packer_if #(
   parameter int SIZE_DATA_I  = 8,
   parameter int SIZE_DATA_O  = 32,
   parameter int NUM_OPERANDS = 2
) ();

   logic                                  i_stick;
   logic                                  i_clear;
   logic                                  i_byte_valid;
   logic [SIZE_DATA_I-1:0]                i_byte_data;
   logic                                  i_frame_err;
   logic                                  i_ready;
   logic [NUM_OPERANDS*SIZE_DATA_O-1:0]   o_operands;
   logic [NUM_OPERANDS-1:0]               o_operand_done;
   logic                                  o_valid;
   logic                                  o_timeout;
   logic                                  o_frame_err;
   logic                                  o_overrun;
   logic                                  o_busy;

   modport master (
      output i_stick, i_clear, i_byte_valid, i_byte_data, i_frame_err, i_ready,
      input  o_operands, o_operand_done, o_valid, o_timeout, o_frame_err, o_overrun, o_busy
   );

   modport slave (
      input  i_stick, i_clear, i_byte_valid, i_byte_data, i_frame_err, i_ready,
      output o_operands, o_operand_done, o_valid, o_timeout, o_frame_err, o_overrun, o_busy
   );

endinterface

// File: rtl/uart_rx_timeout_cnt.sv
// Inter-byte silence timer: down-counts oversample ticks and flags the terminal tick.
module uart_rx_timeout_cnt #(
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_restart,
   input  logic i_enable,
   input  logic i_tick,
   output logic o_tc
);

   localparam int CW = $clog2(TIMEOUT_TICKS + 1);

   logic [CW-1:0] remain;

   // Restart (a byte landing) beats the terminal tick in the same cycle.
   assign o_tc = i_enable & i_tick & ~i_restart & ~i_clear & (remain == CW'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         remain <= '0;
      end else if (i_clear) begin
         remain <= '0;
      end else if (i_restart) begin
         remain <= CW'(TIMEOUT_TICKS);
      end else if (i_enable && i_tick && (remain != '0)) begin
         remain <= remain - CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_operand_packer.sv
// Assembles NUM_OPERANDS operands from the UART byte stream and offers them as one frame.
//
// state   | meaning
// IDLE    | waiting for the first byte of a frame
// COLLECT | frame partially received, timeout armed
// HOLD    | full frame on o_operands, waiting for i_ready
module uart_rx_operand_packer
   import uart_rx_pkg::*;
#(
   parameter int SIZE_DATA_I   = 8,
   parameter int SIZE_DATA_O   = 32,
   parameter int NUM_OPERANDS  = 2,
   parameter bit MSB_FIRST     = 1'b1,
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   uart_rx_operand_packer_if.slave   rx
);

   localparam int BPO = bytes_per_operand(SIZE_DATA_O, SIZE_DATA_I);
   localparam int BCW = cnt_width(BPO);
   localparam int OIW = cnt_width(NUM_OPERANDS);

   if (!sizes_ok(SIZE_DATA_O, SIZE_DATA_I, NUM_OPERANDS)) begin : g_size_check
      $error("SIZE_DATA_O must be a positive multiple of SIZE_DATA_I and NUM_OPERANDS >= 1");
   end

   rx_state_e               state;
   logic [BCW-1:0]          byte_cnt;
   logic [OIW-1:0]          op_idx;
   logic [SIZE_DATA_O-1:0]  op_reg [NUM_OPERANDS];
   logic [SIZE_DATA_O-1:0]  op_shifted;
   logic [NUM_OPERANDS-1:0] done_q;
   logic                    valid_q;
   logic                    busy_q;
   logic                    timeout_q;
   logic                    frame_err_q;
   logic                    overrun_q;

   logic good_byte;
   logic bad_byte;
   logic accept;
   logic last_byte;
   logic last_op;
   logic tmo_tc;

   assign good_byte = rx.i_byte_valid & ~rx.i_frame_err;
   assign bad_byte  = rx.i_byte_valid &  rx.i_frame_err;
   // In HOLD a byte only lands when the consumer takes the frame that same cycle.
   assign accept    = good_byte & ~rx.i_clear & ((state != HOLD) | rx.i_ready);
   assign last_byte = (byte_cnt == BCW'(BPO - 1));
   assign last_op   = (op_idx == OIW'(NUM_OPERANDS - 1));

   if (BPO == 1) begin : g_load
      assign op_shifted = rx.i_byte_data;
   end else if (MSB_FIRST) begin : g_shift_msb
      assign op_shifted = {op_reg[op_idx][SIZE_DATA_O-SIZE_DATA_I-1:0], rx.i_byte_data};
   end else begin : g_shift_lsb
      assign op_shifted = {rx.i_byte_data, op_reg[op_idx][SIZE_DATA_O-1:SIZE_DATA_I]};
   end

   uart_rx_timeout_cnt #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (rx.i_clear),
      .i_restart (accept),
      .i_enable  (state == COLLECT),
      .i_tick    (rx.i_stick),
      .o_tc      (tmo_tc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         op_idx      <= '0;
         done_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int k = 0; k < NUM_OPERANDS; k++) begin
            op_reg[k] <= '0;
         end
      end else begin
         done_q      <= '0;
         timeout_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (rx.i_clear) begin
            state    <= IDLE;
            byte_cnt <= '0;
            op_idx   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
         end else if (accept) begin
            op_reg[op_idx] <= op_shifted;
            if (last_byte) begin
               byte_cnt       <= '0;
               done_q[op_idx] <= 1'b1;
               if (last_op) begin
                  op_idx  <= '0;
                  state   <= HOLD;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  op_idx  <= op_idx + OIW'(1);
                  state   <= COLLECT;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end else begin
               byte_cnt <= byte_cnt + BCW'(1);
               state    <= COLLECT;
               valid_q  <= 1'b0;
               busy_q   <= 1'b1;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (bad_byte) frame_err_q <= 1'b1;
               end
               COLLECT: begin
                  if (bad_byte || tmo_tc) begin
                     state       <= IDLE;
                     byte_cnt    <= '0;
                     op_idx      <= '0;
                     busy_q      <= 1'b0;
                     frame_err_q <= bad_byte;
                     timeout_q   <= ~bad_byte;
                  end
               end
               HOLD: begin
                  if (rx.i_ready) begin
                     state       <= IDLE;
                     valid_q     <= 1'b0;
                     frame_err_q <= bad_byte;
                  end else if (rx.i_byte_valid) begin
                     overrun_q <= 1'b1;
                  end
               end
               default: begin
                  state    <= IDLE;
                  byte_cnt <= '0;
                  op_idx   <= '0;
                  valid_q  <= 1'b0;
                  busy_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_out
      assign rx.o_operands[k*SIZE_DATA_O +: SIZE_DATA_O] = op_reg[k];
   end

   assign rx.o_operand_done = done_q;
   assign rx.o_valid        = valid_q;
   assign rx.o_busy         = busy_q;
   assign rx.o_timeout      = timeout_q;
   assign rx.o_frame_err    = frame_err_q;
   assign rx.o_overrun      = overrun_q;

endmodule

// File: doc/uart_rx_operand_packer.md
Name: uart_rx_operand_packer

Overview:
Parametrised successor to the two-operand UART receive path. Consumes the byte stream from the UART receiver core and assembles NUM_OPERANDS operands of SIZE_DATA_O bits each, with selectable byte order. Adds per-operand completion pulses, a valid/ready output handshake, an inter-byte timeout, frame-error discard and overrun detection. Sits between the UART receiver and the floating-point datapath.

Parameters:
SIZE_DATA_I, 8, byte width from the receiver.
SIZE_DATA_O, 32, operand width; must be an integer multiple of SIZE_DATA_I, otherwise elaboration error.
NUM_OPERANDS, 2, operands per frame (≥1).
MSB_FIRST, 1, 1 = first byte of an operand is its most significant byte; 0 = least significant first.
TIMEOUT_TICKS, 640, i_stick pulses of silence allowed between bytes inside a frame (4 byte-times at 16x oversample).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_stick  in  1  baud oversample tick, 1-cycle pulse
i_clear  in  1  synchronous soft clear
i_byte_valid  in  1  1-cycle pulse: received byte available
i_byte_data  in  SIZE_DATA_I  received byte
i_frame_err  in  1  qualifies i_byte_valid: stop-bit error on this byte
o_operands  out  NUM_OPERANDS*SIZE_DATA_O  operand k at [k*SIZE_DATA_O +: SIZE_DATA_O]; operand 0 is received first
o_operand_done  out  NUM_OPERANDS  1-cycle pulse per operand completed
o_valid  out  1  full frame held on o_operands
i_ready  in  1  consumer accepts frame
o_timeout  out  1  1-cycle pulse: partial frame discarded on timeout
o_frame_err  out  1  1-cycle pulse: frame discarded on byte error
o_overrun  out  1  1-cycle pulse: byte dropped while holding
o_busy  out  1  frame collection in progress (state COLLECT)

Behaviour:
- BPO = SIZE_DATA_O/SIZE_DATA_I. Byte counter range 0..BPO-1; operand index range 0..NUM_OPERANDS-1; widths are $clog2 with a minimum of 1.
- Reset (async, i_rst_n=0): state IDLE, all outputs 0, counters 0, operand registers 0.
- FSM states:
  - IDLE: on a good byte -> COLLECT with count 1.
  - COLLECT: good byte -> shift in. Last byte of the last operand -> HOLD.
  - HOLD: o_valid=1. i_ready=1 -> IDLE.
- Shifting with MSB_FIRST=1: op <= {op[SIZE_DATA_O-SIZE_DATA_I-1:0], byte}. With MSB_FIRST=0: op <= {byte, op[SIZE_DATA_O-1:SIZE_DATA_I]}. When BPO=1 the byte is loaded directly.
- Completion latency:
  - o_operand_done[k] pulses the cycle after operand k's last byte is accepted.
  - o_valid rises the cycle after the final byte and stays high until the handshake.
  - o_operands is stable throughout HOLD.
- Frame error (i_byte_valid & i_frame_err) in IDLE or COLLECT: discard the partial frame, pulse o_frame_err, go to IDLE. Operand registers are not cleared; o_valid stays 0.
- Timeout:
  - Counter counts i_stick pulses in COLLECT only; it resets on each accepted byte.
  - Reaching TIMEOUT_TICKS: pulse o_timeout, go to IDLE.
  - A byte arriving in the same cycle as the terminal tick wins: it is accepted and there is no timeout.
- HOLD with i_byte_valid and i_ready=0: byte dropped, o_overrun pulses, operands unchanged.
- HOLD with i_byte_valid and i_ready=1 in the same cycle: handshake completes and the byte is accepted as byte 0 of the next frame (-> COLLECT, count 1). A frame error in this case goes to IDLE with an o_frame_err pulse.
- i_clear has the highest priority over all events:
  - Next state IDLE; o_valid=0; counters 0.
  - No status pulses are generated.
  - Operand registers are retained.
- Status pulses are registered and never last longer than 1 cycle.

Decomposition:
- Package uart_rx_pkg:
  - state enum typedef (IDLE, COLLECT, HOLD).
  - localparam helpers for BPO and counter widths.
  - Elaboration-time divisibility check.
- One sub-module, uart_rx_timeout_cnt: counts i_stick pulses, with restart and enable inputs and a terminal-count pulse output.

Test Plan:
1. Defaults, bytes 3F 80 00 00 40 00 00 00 -> o_operand_done[0] pulse after byte 4, o_operand_done[1] pulse and o_valid after byte 8, operand0=32'h3F800000, operand1=32'h40000000; i_ready=1 -> o_valid=0 next cycle.
2. MSB_FIRST=0, same bytes -> operand0=32'h0000803F, operand1=32'h00000040.
3. 3 bytes, then 640 stick ticks of silence -> o_timeout single pulse, o_busy=0, no o_valid; a following full 8-byte frame assembles correctly.
4. Frame error flagged on byte 5 -> o_frame_err pulse, IDLE, o_valid stays 0; next clean frame assembles correctly.
5. HOLD with i_ready=0, byte AA -> o_overrun pulse, operands unchanged. Then i_ready=1 coincident with byte BB -> handshake completes, o_busy=1, count 1; three more bytes complete operand0=BBxxxxxx.
6. Async reset after byte 5 -> all outputs 0 immediately; after release, a full frame yields correct operands; i_clear mid-frame -> IDLE with no pulses.
